// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB master.
// Contents:
//   apb_state_e - transfer FSM state encoding (IDLE, SETUP, ACCESS)
//   slave_sel   - maps the slave-select address bit to a one-hot psel value
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic logic [1:0] slave_sel(input logic msb);
    return msb ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
// Ports:
//   valid[1:0] - request valid per requester
//   last       - index of the requester granted most recently
//   grant[1:0] - one-hot grant, zero when no request is valid
module apb_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      // Contention: the requester that was not served last time wins.
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters through a round-robin arbiter.
// Ports:
//   pclk, preset              - clock and synchronous active-high reset
//   req_valid/ready/write     - per-requester handshake and direction
//   req_addr/wdata/strb       - per-requester request fields, packed by index
//   rsp_valid/rdata/err       - one-cycle completion pulse to the owner
//   psel/penable/pwrite/paddr/pwdata/pstrb - APB request bus
//   prdata/pready/pslverr     - APB slave response
//   fsm_state                 - current transfer state, for observation
// Handshake: a request is transferred on a rising edge where req_valid[i]
// and req_ready[i] are both high; req_ready only rises in IDLE, and the
// requester keeps its fields stable until then.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int ADD_WIDTH = 9,
  parameter int WIDTH     = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_write,
  input  logic [2*ADD_WIDTH-1:0]   req_addr,
  input  logic [2*WIDTH-1:0]       req_wdata,
  input  logic [2*(WIDTH/8)-1:0]   req_strb,
  output logic [1:0]               rsp_valid,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     rsp_err,
  output logic [1:0]               psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADD_WIDTH-1:0]     paddr,
  output logic [WIDTH-1:0]         pwdata,
  output logic [WIDTH/8-1:0]       pstrb,
  input  logic [WIDTH-1:0]         prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output apb_state_e               fsm_state
);

  localparam int SW = WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  apb_state_e           state_q, state_d;
  logic [1:0]           grant;
  logic                 accept, done, abort;
  logic                 last_q, own_q, wr_q;
  logic [ADD_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]     wdata_q;
  logic [SW-1:0]        strb_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           rsp_valid_q;
  logic [WIDTH-1:0]     rsp_rdata_q;
  logic                 rsp_err_q;

  apb_rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // No acceptance while reset is asserted: that edge discards everything.
  assign accept    = (state_q == IDLE) && (grant != 2'b00) && !preset;
  assign req_ready = accept ? grant : 2'b00;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        // pready takes priority over a timeout in the same cycle.
        if (pready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      own_q       <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 2'b00;
      if (accept) begin
        own_q   <= grant[1];
        last_q  <= grant[1];
        wr_q    <= grant[1] ? req_write[1] : req_write[0];
        addr_q  <= grant[1] ? req_addr[2*ADD_WIDTH-1:ADD_WIDTH] : req_addr[ADD_WIDTH-1:0];
        wdata_q <= grant[1] ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
        strb_q  <= grant[1] ? req_strb[2*SW-1:SW] : req_strb[SW-1:0];
      end
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == ACCESS && !pready) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (done) begin
        rsp_valid_q <= own_q ? 2'b10 : 2'b01;
        rsp_rdata_q <= wr_q ? '0 : prdata;
        rsp_err_q   <= pslverr;
      end else if (abort) begin
        rsp_valid_q <= own_q ? 2'b10 : 2'b01;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  // Bus outputs are decoded from the state and the captured request so
  // that they are stable for the whole SETUP/ACCESS window.
  assign psel      = (state_q == IDLE) ? 2'b00 : slave_sel(addr_q[ADD_WIDTH-1]);
  assign penable   = (state_q == ACCESS);
  assign pwrite    = wr_q;
  assign paddr     = addr_q;
  assign pwdata    = wr_q ? wdata_q : '0;
  assign pstrb     = wr_q ? strb_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: drivers push expected APB setups and
// responses into queues; a monitor pops and compares when the DUT shows them.
module tb_apb_arb_master;
  import apb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic            pclk;
  logic            preset;
  logic [1:0]      req_valid, req_ready, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*SW-1:0] req_strb;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [1:0]      psel;
  logic            penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [SW-1:0]   pstrb;
  logic [DW-1:0]   prdata;
  logic            pready, pslverr;
  apb_state_e      fsm_state;

  apb_arb_master #(.ADD_WIDTH(AW), .WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .fsm_state(fsm_state)
  );

  int check_n = 0;
  int err_n   = 0;
  int cyc     = 0;
  int acc_cyc [2];

  // {psel, pwrite, paddr, pwdata, pstrb}
  logic [47:0] apb_exp_q[$];
  // {rsp_valid, rsp_err, rsp_rdata, latency from accept}
  logic [42:0] rsp_exp_q[$];

  int          slave_wait  = 0;
  logic [31:0] slave_rdata = '0;
  logic        slave_err   = 1'b0;

  // ---------------- clock / reset ----------------
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    err_n++;
    $display("CHECKS %0d ERRORS %0d", check_n, err_n);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    check_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- APB slave model ----------------
  initial begin : slave
    int acc_n;
    acc_n   = 0;
    pready  = 1'b0;
    prdata  = 32'h0BAD_0BAD;
    pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (penable) begin
        pready  = (acc_n >= slave_wait);
        prdata  = pready ? slave_rdata : 32'h0BAD_0BAD;
        pslverr = pready ? slave_err : 1'b0;
        acc_n++;
      end else begin
        acc_n  = 0;
        pready = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_xfer(input int id, input logic wr, input logic [8:0] addr,
                             input logic [31:0] wd, input logic [3:0] st,
                             input logic [31:0] rd, input logic err, input int acc_len);
    logic [1:0] ps;
    ps = addr[8] ? 2'b10 : 2'b01;
    apb_exp_q.push_back({ps, wr, addr, (wr ? wd : 32'h0), (wr ? st : 4'h0)});
    rsp_exp_q.push_back({(id == 1 ? 2'b10 : 2'b01), err, (wr ? 32'h0 : rd), 8'(2 + acc_len)});
  endtask

  task automatic drive_req(input int id, input logic wr, input logic [8:0] addr,
                           input logic [31:0] wd, input logic [3:0] st);
    bit got;
    got = 1'b0;
    req_write[id]           = wr;
    req_addr[id*AW +: AW]   = addr;
    req_wdata[id*DW +: DW]  = wd;
    req_strb[id*SW +: SW]   = st;
    req_valid[id]           = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge pclk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge pclk);
    #1;
    req_valid[id] = 1'b0;
    chk($sformatf("req_ready_%0d", id), 64'(got), 64'd1);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((apb_exp_q.size() != 0 || rsp_exp_q.size() != 0) && k < 100) begin
      @(negedge pclk);
      k++;
    end
    chk("drain", 64'(apb_exp_q.size() + rsp_exp_q.size()), 64'd0);
    @(posedge pclk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_state"}, 64'(fsm_state), 64'(IDLE));
    chk({nm, "_bus"}, {psel, penable, pwrite, paddr, pwdata, pstrb}, 64'd0);
    chk({nm, "_hs"}, {req_ready, rsp_valid, rsp_err}, 64'd0);
    chk({nm, "_rdata"}, 64'(rsp_rdata), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [47:0] mon_cur, mon_snap, mon_apb_e;
  logic [42:0] mon_rsp_e;
  int          mon_idx;

  initial begin
    mon_snap = '0;
    forever begin
      @(negedge pclk);
      for (int i = 0; i < 2; i++) if (req_ready[i]) acc_cyc[i] = cyc;
      mon_cur = {psel, pwrite, paddr, pwdata, pstrb};
      if (psel != 2'b00 && !penable) begin
        if (apb_exp_q.size() == 0) begin
          check_n++;
          err_n++;
          $display("FAIL apb_unexpected act=%0h exp=none", mon_cur);
        end else begin
          mon_apb_e = apb_exp_q.pop_front();
          chk("apb_setup", 64'(mon_cur), 64'(mon_apb_e));
          mon_snap = mon_cur;
        end
      end else if (penable) begin
        chk("apb_stable", 64'(mon_cur), 64'(mon_snap));
      end
      if (rsp_valid != 2'b00) begin
        if (rsp_exp_q.size() == 0) begin
          check_n++;
          err_n++;
          $display("FAIL rsp_unexpected act=%0h exp=none", rsp_valid);
        end else begin
          mon_rsp_e = rsp_exp_q.pop_front();
          mon_idx   = rsp_valid[1] ? 1 : 0;
          chk("rsp", 64'({rsp_valid, rsp_err, rsp_rdata, 8'(cyc - acc_cyc[mon_idx])}),
              64'(mon_rsp_e));
          chk("rsp_bus_idle", 64'({psel, penable}), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    preset    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    repeat (2) @(posedge pclk);
    #1;
    check_reset_outputs("reset");
    req_valid = 2'b11;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    @(posedge pclk);
    #1;
    preset = 1'b0;

    // Contention after reset: requester 0 first, requester 1 in the completion cycle.
    slave_wait = 0; slave_rdata = 32'h0000_1234; slave_err = 1'b0;
    expect_xfer(0, 1'b0, 9'h001, 32'hFFFF_FFFF, 4'hF, 32'h0000_1234, 1'b0, 1);
    expect_xfer(1, 1'b0, 9'h101, 32'hFFFF_FFFF, 4'hF, 32'h0000_1234, 1'b0, 1);
    fork
      drive_req(0, 1'b0, 9'h001, 32'hFFFF_FFFF, 4'hF);
      drive_req(1, 1'b0, 9'h101, 32'hFFFF_FFFF, 4'hF);
    join
    wait_drain();

    // Single write, zero wait states: response three cycles after accept.
    slave_rdata = 32'h0000_0077;
    expect_xfer(0, 1'b1, 9'h003, 32'h0000_00A5, 4'hF, 32'h0, 1'b0, 1);
    drive_req(0, 1'b1, 9'h003, 32'h0000_00A5, 4'hF);
    wait_drain();

    // Contention again with requester 0 granted last: requester 1 goes first.
    slave_rdata = 32'h0000_5678;
    expect_xfer(1, 1'b0, 9'h101, 32'h0, 4'h0, 32'h0000_5678, 1'b0, 1);
    expect_xfer(0, 1'b0, 9'h001, 32'h0, 4'h0, 32'h0000_5678, 1'b0, 1);
    fork
      drive_req(0, 1'b0, 9'h001, 32'h0, 4'h0);
      drive_req(1, 1'b0, 9'h101, 32'h0, 4'h0);
    join
    wait_drain();

    // Three wait states.
    slave_wait = 3; slave_rdata = 32'hDEAD_BEEF;
    expect_xfer(1, 1'b0, 9'h102, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 4);
    drive_req(1, 1'b0, 9'h102, 32'h0, 4'hF);
    wait_drain();

    // Slave never ready: abort after TIMEOUT ACCESS cycles, then a normal read.
    slave_wait = 1000; slave_rdata = 32'h9999_9999;
    expect_xfer(0, 1'b0, 9'h020, 32'h0, 4'h0, 32'h0, 1'b1, TO);
    drive_req(0, 1'b0, 9'h020, 32'h0, 4'h0);
    wait_drain();
    slave_wait = 0; slave_rdata = 32'h1234_5678;
    expect_xfer(1, 1'b0, 9'h005, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1);
    drive_req(1, 1'b0, 9'h005, 32'h0, 4'h0);
    wait_drain();

    // pready arrives in the last ACCESS cycle: normal completion wins.
    slave_wait = TO - 1; slave_rdata = 32'h0F0F_0F0F;
    expect_xfer(0, 1'b0, 9'h030, 32'h0, 4'h0, 32'h0F0F_0F0F, 1'b0, TO);
    drive_req(0, 1'b0, 9'h030, 32'h0, 4'h0);
    wait_drain();

    // Slave error on a write, then on a read with nonzero requested strobes.
    slave_wait = 0; slave_err = 1'b1; slave_rdata = 32'hCAFE_F00D;
    expect_xfer(0, 1'b1, 9'h0FF, 32'h0000_CAFE, 4'h3, 32'h0, 1'b1, 1);
    drive_req(0, 1'b1, 9'h0FF, 32'h0000_CAFE, 4'h3);
    wait_drain();
    expect_xfer(1, 1'b0, 9'h0AA, 32'h5555_5555, 4'hF, 32'hCAFE_F00D, 1'b1, 1);
    drive_req(1, 1'b0, 9'h0AA, 32'h5555_5555, 4'hF);
    wait_drain();
    slave_err = 1'b0;

    // Reset during ACCESS: transfer abandoned, no response.
    slave_wait = 1000;
    expect_xfer(0, 1'b1, 9'h1F0, 32'h1122_3344, 4'hA, 32'h0, 1'b0, 1);
    void'(rsp_exp_q.pop_back());
    drive_req(0, 1'b1, 9'h1F0, 32'h1122_3344, 4'hA);
    repeat (3) @(posedge pclk);
    #1;
    chk("pre_reset_state", 64'(fsm_state), 64'(ACCESS));
    preset = 1'b1;
    @(posedge pclk);
    #1;
    check_reset_outputs("mid_reset");
    preset = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_queues", 64'(apb_exp_q.size() + rsp_exp_q.size()), 64'd0);

    // First contention after reset goes to requester 0.
    slave_wait = 0; slave_rdata = 32'h0000_ABCD;
    expect_xfer(0, 1'b0, 9'h044, 32'h0, 4'h0, 32'h0000_ABCD, 1'b0, 1);
    expect_xfer(1, 1'b0, 9'h144, 32'h0, 4'h0, 32'h0000_ABCD, 1'b0, 1);
    fork
      drive_req(0, 1'b0, 9'h044, 32'h0, 4'h0);
      drive_req(1, 1'b0, 9'h144, 32'h0, 4'h0);
    join
    wait_drain();

    repeat (3) @(posedge pclk);
    $display("CHECKS %0d ERRORS %0d", check_n, err_n);
    $finish;
  end

endmodule
